i2c_reg_writer: RTL and testbench
=================================

Name: i2c_reg_writer

Overview:
- Self-contained I2C master that performs one complete register-write transaction per request: START, device address with write bit, register address bytes, a burst of data bytes, then STOP.
- Successor to the single-byte writer. It adds a parametrised register-address width, burst length and SCL divider, its own bit engine, ACK checking with NACK abort, and busy/error status.
- Sits between the codec-configuration sequencer and the open-drain SDA/SCL pads.

Parameters:
- CLK_DIV, 32: sys_clk cycles per SCL quarter-period (must be at least 1).
- REG_BYTES, 1: register-address bytes sent, MSB first (1 or 2).
- MAX_DATA_BYTES, 4: largest burst size (1 to 8).
- NB_W, $clog2(MAX_DATA_BYTES)+1: width of nbytes.

Ports:
- sys_clk, input, 1: system clock; all logic is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- write, input, 1: request. Sampled only when idle.
- dev_addr, input, 7: 7-bit device address.
- reg_addr, input, 8*REG_BYTES: register address.
- data, input, 8*MAX_DATA_BYTES: payload. The first byte sent is data[8*nbytes-1 -: 8].
- nbytes, input, NB_W: number of data bytes to send.
- sda_in, input, 1: SDA pad level (already synchronised externally).
- sda_oe, output, 1: 1 = pull SDA low, 0 = release.
- scl_oe, output, 1: 1 = pull SCL low, 0 = release.
- busy, output, 1: a transaction is in progress.
- done, output, 1: single-cycle pulse at the end of a transaction.
- ack_error, output, 1: the last transaction saw a NACK. Held until the next accepted write.

Behaviour:
- Reset (asynchronous):
  - sda_oe=0, scl_oe=0, busy=0, done=0, ack_error=0.
  - FSM goes to IDLE; divider and all counters clear.
  - Reset asserted mid-transaction releases both lines immediately; no STOP is generated.
- Acceptance:
  - write=1 while in IDLE latches dev_addr, reg_addr, data and nbytes.
  - ack_error is cleared and busy=1 from the next cycle.
  - write is ignored while busy, including in the done cycle.
- nbytes clamping:
  - nbytes=0 sends no data bytes (register-pointer-only write).
  - nbytes>MAX_DATA_BYTES is clamped to MAX_DATA_BYTES.
- Quarter tick: a divider counts 0..CLK_DIV-1. Every phase below lasts exactly one quarter (CLK_DIV cycles).
- FSM states: IDLE -> START -> BYTE -> ACK -> (BYTE | STOP) -> DONE -> IDLE.
- START, quarters q0..q3 (sda_oe/scl_oe):
  - q0: 0/0
  - q1: 1/0
  - q2: 1/0
  - q3: 1/1
- BYTE, 8 bits MSB first, each bit q0..q3:
  - q0 and q1: scl_oe=1, sda_oe=~bit.
  - q2 and q3: scl_oe=0, sda_oe unchanged.
- ACK:
  - sda_oe=0; SCL pattern as for a data bit.
  - sda_in is sampled on the last cycle of q2. A 1 is a NACK.
- Byte order:
  - {dev_addr,1'b0}
  - reg_addr bytes, MSB first
  - then nbytes data bytes, MSB first
- NACK on any byte: ack_error=1, all remaining bytes are skipped, and the FSM goes to STOP.
- STOP, quarters q0..q3 (sda_oe/scl_oe):
  - q0: 1/1
  - q1: 1/0
  - q2: 1/0
  - q3: 0/0
- DONE: lasts one cycle with done=1 and busy=0, then IDLE. The next write can be accepted in the following cycle.
- Latency: from the cycle write is sampled to the done pulse = 1 + CLK_DIV*(8 + 36*(1+REG_BYTES+N)) cycles, where N is the clamped nbytes. A NACK shortens N accordingly.
- SCL is never released while SDA changes, except during the START and STOP edges.
- No clock stretching and no arbitration: scl is not read back.

Test Plan:
- CLK_DIV=4, REG_BYTES=1, dev_addr=0x1A, reg_addr=0x0E, nbytes=1, data byte 0x42, sda_in always 0:
  - bit sequence on SDA is 0x34, 0x0E, 0x42;
  - done arrives 465 cycles after write;
  - ack_error=0.
- Same setup with nbytes=3 and data 0xAABBCC:
  - bytes sent in order 0xAA, 0xBB, 0xCC;
  - latency is 1+4*(8+36*5)=753 cycles.
- NACK: drive sda_in=1 during the second ACK:
  - STOP follows immediately;
  - ack_error=1 with done;
  - no data bytes are sent;
  - latency is 1+4*(8+72)=321 cycles.
- Boundary values:
  - nbytes=0 sends only the address and register bytes;
  - nbytes=7 with MAX_DATA_BYTES=4 sends exactly 4 data bytes.
- Reset mid-byte:
  - sda_oe and scl_oe fall to 0 asynchronously and busy=0;
  - a subsequent write completes normally.
- Pulse write while busy:
  - the request is ignored;
  - exactly one done pulse is produced;
  - REG_BYTES=2 with reg_addr=0x1234 sends 0x12 then 0x34.

Source files
------------

// File: rtl/i2c_reg_writer_if.sv
// Request/status and pad bundle between the codec-config sequencer and i2c_reg_writer.
// Latency: none (wires only).
// Backpressure: write is accepted only while the writer is idle; busy tells the requester to hold off.
//
// Signals:
//   write      request strobe (sequencer -> writer)
//   dev_addr   7-bit device address
//   reg_addr   register address, REG_BYTES bytes, MSB byte sent first
//   data       payload; first byte sent is data[8*nbytes-1 -: 8]
//   nbytes     number of payload bytes (clamped to MAX_DATA_BYTES)
//   sda_in     synchronised SDA pad level
//   sda_oe     1 = pull SDA low
//   scl_oe     1 = pull SCL low
//   busy       transaction in progress
//   done       one-cycle end-of-transaction pulse
//   ack_error  last transaction saw a NACK
interface i2c_reg_writer_if #(
   parameter int REG_BYTES      = 1,
   parameter int MAX_DATA_BYTES = 4,
   parameter int NB_W           = $clog2(MAX_DATA_BYTES) + 1
);
   logic                        write;
   logic [6:0]                  dev_addr;
   logic [8*REG_BYTES-1:0]      reg_addr;
   logic [8*MAX_DATA_BYTES-1:0] data;
   logic [NB_W-1:0]             nbytes;
   logic                        sda_in;
   logic                        sda_oe;
   logic                        scl_oe;
   logic                        busy;
   logic                        done;
   logic                        ack_error;

   // Requester side (sequencer plus the pad input).
   modport master (
      output write, dev_addr, reg_addr, data, nbytes, sda_in,
      input  sda_oe, scl_oe, busy, done, ack_error
   );

   // Writer side.
   modport slave (
      input  write, dev_addr, reg_addr, data, nbytes, sda_in,
      output sda_oe, scl_oe, busy, done, ack_error
   );
endinterface

// File: rtl/i2c_reg_writer.sv
// I2C master doing one register write per request: START, {dev,W}, reg bytes, data burst, STOP.
// Latency: write-sampled cycle to done = 1 + CLK_DIV*(8 + 36*(1+REG_BYTES+N)) cycles, N = clamped nbytes.
// Backpressure: requests are ignored while busy and in the done cycle; a NACK aborts to STOP.
//
// Ports:
//   sys_clk  system clock, rising edge
//   reset    asynchronous active-high reset; releases both pad lines at once
//   bus      i2c_reg_writer_if.slave (request fields, sda_in, pad enables, status)
module i2c_reg_writer #(
   parameter int CLK_DIV        = 32,
   parameter int REG_BYTES      = 1,
   parameter int MAX_DATA_BYTES = 4,
   parameter int NB_W           = $clog2(MAX_DATA_BYTES) + 1
) (
   input  logic            sys_clk,
   input  logic            reset,
   i2c_reg_writer_if.slave bus
);

   // Whole transaction is held in one left-aligned shift register:
   // {dev_addr, W, reg_addr, payload}. The current bit is always the MSB.
   localparam int SW = 8 * (1 + REG_BYTES + MAX_DATA_BYTES);
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int LW = $clog2(REG_BYTES + MAX_DATA_BYTES + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BYTE,
      S_ACK,
      S_STOP,
      S_DONE
   } state_t;

   state_t          state_q,  state_d;
   logic [DW-1:0]   div_q,    div_d;
   logic [1:0]      qtr_q,    qtr_d;
   logic [2:0]      bit_q,    bit_d;
   logic [SW-1:0]   stream_q, stream_d;
   logic [LW-1:0]   left_q,   left_d;
   logic            sda_q,    sda_d;
   logic            scl_q,    scl_d;
   logic            busy_q,   busy_d;
   logic            done_q,   done_d;
   logic            ackerr_q, ackerr_d;

   logic                        qtr_end;
   logic [NB_W-1:0]             n_clamp;
   logic [8*MAX_DATA_BYTES-1:0] data_al;

   assign qtr_end = (div_q == DW'(CLK_DIV - 1));

   // Payload is left-aligned at acceptance so that data[8*n-1 -: 8] lands
   // directly behind the register address; unused low bytes become zero and
   // are never shifted out because left_q stops the burst first.
   always_comb begin
      n_clamp = (bus.nbytes > NB_W'(MAX_DATA_BYTES)) ? NB_W'(MAX_DATA_BYTES) : bus.nbytes;
      data_al = bus.data << (8 * (MAX_DATA_BYTES - int'(n_clamp)));
   end

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      qtr_d    = qtr_q;
      bit_d    = bit_q;
      stream_d = stream_q;
      left_d   = left_q;
      busy_d   = busy_q;
      ackerr_d = ackerr_q;
      done_d   = 1'b0;
      sda_d    = 1'b0;
      scl_d    = 1'b0;

      // Quarter timing runs only while the bus is being driven.
      if (state_q != S_IDLE && state_q != S_DONE) begin
         div_d = qtr_end ? '0 : div_q + DW'(1);
         if (qtr_end) begin
            qtr_d = qtr_q + 2'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.write) begin
               state_d  = S_START;
               div_d    = '0;
               qtr_d    = 2'd0;
               bit_d    = 3'd0;
               stream_d = {bus.dev_addr, 1'b0, bus.reg_addr, data_al};
               left_d   = LW'(1 + REG_BYTES) + LW'(n_clamp);
               busy_d   = 1'b1;
               ackerr_d = 1'b0;
            end
         end
         S_START: begin
            if (qtr_end && qtr_q == 2'd3) begin
               state_d = S_BYTE;
               bit_d   = 3'd0;
            end
         end
         S_BYTE: begin
            if (qtr_end && qtr_q == 2'd3) begin
               stream_d = stream_q << 1;
               if (bit_q == 3'd7) begin
                  state_d = S_ACK;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_ACK: begin
            // Slave's ACK is read on the last cycle of q2, mid SCL-high.
            if (qtr_end && qtr_q == 2'd2 && bus.sda_in) begin
               ackerr_d = 1'b1;
            end
            if (qtr_end && qtr_q == 2'd3) begin
               if (ackerr_q || left_q == LW'(1)) begin
                  state_d = S_STOP;
               end else begin
                  state_d = S_BYTE;
                  bit_d   = 3'd0;
                  left_d  = left_q - LW'(1);
               end
            end
         end
         S_STOP: begin
            if (qtr_end && qtr_q == 2'd3) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Pad enables are decoded from the next state so they are registered
      // and line up exactly with the quarter they belong to.
      case (state_d)
         S_START: begin
            sda_d = (qtr_d != 2'd0);
            scl_d = (qtr_d == 2'd3);
         end
         S_BYTE: begin
            // Bit is stable for all four quarters; it only changes when the
            // stream shifts at the q3->q0 boundary, where SCL is pulled low.
            sda_d = ~stream_d[SW-1];
            scl_d = ~qtr_d[1];
         end
         S_ACK: begin
            sda_d = 1'b0;
            scl_d = ~qtr_d[1];
         end
         S_STOP: begin
            sda_d = (qtr_d != 2'd3);
            scl_d = (qtr_d == 2'd0);
         end
         default: begin
            sda_d = 1'b0;
            scl_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         qtr_q    <= 2'd0;
         bit_q    <= 3'd0;
         stream_q <= '0;
         left_q   <= '0;
         sda_q    <= 1'b0;
         scl_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ackerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         qtr_q    <= qtr_d;
         bit_q    <= bit_d;
         stream_q <= stream_d;
         left_q   <= left_d;
         sda_q    <= sda_d;
         scl_q    <= scl_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ackerr_q <= ackerr_d;
      end
   end

   assign bus.sda_oe    = sda_q;
   assign bus.scl_oe    = scl_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.ack_error = ackerr_q;

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Directed bench for i2c_reg_writer: two instances (1- and 2-byte register address).
// Expected SDA bytes are queued when a request is driven and checked as the bus monitor decodes them.
// Latency is counted from the cycle in which write is presented to the cycle carrying done.
module tb_i2c_reg_writer;

   logic sys_clk = 1'b0;
   logic reset   = 1'b1;
   always #5 sys_clk = ~sys_clk;

   i2c_reg_writer_if #(.REG_BYTES(1), .MAX_DATA_BYTES(4), .NB_W(3)) if0 ();
   i2c_reg_writer_if #(.REG_BYTES(2), .MAX_DATA_BYTES(4), .NB_W(3)) if1 ();

   i2c_reg_writer #(.CLK_DIV(4), .REG_BYTES(1), .MAX_DATA_BYTES(4), .NB_W(3)) u_dut0 (
      .sys_clk (sys_clk),
      .reset   (reset),
      .bus     (if0.slave)
   );

   i2c_reg_writer #(.CLK_DIV(4), .REG_BYTES(2), .MAX_DATA_BYTES(4), .NB_W(3)) u_dut1 (
      .sys_clk (sys_clk),
      .reset   (reset),
      .bus     (if1.slave)
   );

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] exp_q[$];

   int   sel      = 0;     // which instance the monitor watches
   int   nack_idx = -1;    // byte index whose ACK is answered with NACK
   int   t0       = 0;
   int   done_cnt = 0;
   int   start_cnt = 0;
   int   stop_cnt  = 0;
   int   mon_bits  = 0;
   int   mon_bytes = 0;
   logic [7:0] mon_sh = 8'h00;
   logic p_sda = 1'b0, p_scl = 1'b0;
   logic o_sda, o_scl, o_busy, o_done, o_ackerr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      if (sel == 0) begin
         o_sda = if0.sda_oe; o_scl = if0.scl_oe; o_busy = if0.busy;
         o_done = if0.done;  o_ackerr = if0.ack_error;
      end else begin
         o_sda = if1.sda_oe; o_scl = if1.scl_oe; o_busy = if1.busy;
         o_done = if1.done;  o_ackerr = if1.ack_error;
      end
   endtask

   // One clock step: sample at the falling edge, decode the bus, drive sda_in.
   task automatic tick();
      logic [31:0] e;
      logic        nack;
      @(negedge sys_clk);
      sample();
      if (o_done) done_cnt++;
      if (reset) begin
         mon_bits = 0; mon_bytes = 0; p_sda = 1'b0; p_scl = 1'b0;
      end else begin
         if (!p_scl && !o_scl && !p_sda && o_sda) begin
            start_cnt++; mon_bits = 0; mon_bytes = 0;
         end else if (!p_scl && !o_scl && p_sda && !o_sda) begin
            stop_cnt++;
         end else if (p_scl && !o_scl) begin
            if (mon_bits < 8) begin
               mon_sh = {mon_sh[6:0], ~o_sda};
               mon_bits++;
               if (mon_bits == 8) begin
                  e = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'h1FF;
                  check("sda_byte", {24'd0, mon_sh}, e);
                  mon_bytes++;
               end
            end else begin
               mon_bits = 0;
            end
         end
         p_sda = o_sda;
         p_scl = o_scl;
      end
      nack = (nack_idx >= 0) && (mon_bytes == nack_idx + 1);
      if0.sda_in = (sel == 0) && nack;
      if1.sda_in = (sel == 1) && nack;
   endtask

   task automatic push_expected(input int which, input logic [6:0] dev, input logic [15:0] ra,
                                input logic [31:0] d, input int n, input int nack_at);
      logic [7:0]  b[$];
      logic [31:0] tmp;
      int nb;
      nb = (n > 4) ? 4 : n;
      b.push_back({dev, 1'b0});
      if (which == 1) b.push_back(ra[15:8]);
      b.push_back(ra[7:0]);
      for (int k = 0; k < nb; k++) begin
         tmp = d >> (8 * (nb - 1 - k));
         b.push_back(tmp[7:0]);
      end
      for (int k = 0; k < b.size(); k++) begin
         if (nack_at < 0 || k <= nack_at) exp_q.push_back(b[k]);
      end
   endtask

   task automatic drive_req(input int which, input logic [6:0] dev, input logic [15:0] ra,
                            input logic [31:0] d, input logic [2:0] n);
      if (which == 0) begin
         if0.dev_addr = dev; if0.reg_addr = ra[7:0]; if0.data = d; if0.nbytes = n; if0.write = 1'b1;
      end else begin
         if1.dev_addr = dev; if1.reg_addr = ra; if1.data = d; if1.nbytes = n; if1.write = 1'b1;
      end
   endtask

   task automatic start_write(input int which, input logic [6:0] dev, input logic [15:0] ra,
                              input logic [31:0] d, input logic [2:0] n);
      tick();
      drive_req(which, dev, ra, d, n);
      t0 = cyc;
      tick();
      if0.write = 1'b0;
      if1.write = 1'b0;
      check("accept_busy", {31'd0, o_busy}, 32'd1);
      check("accept_ackerr_clear", {31'd0, o_ackerr}, 32'd0);
   endtask

   task automatic wait_done(output int got);
      got = 0;
      for (int i = 0; i < 4000; i++) begin
         tick();
         if (o_done) begin
            got = 1;
            break;
         end
      end
   endtask

   task automatic run_txn(input int which, input logic [6:0] dev, input logic [15:0] ra,
                          input logic [31:0] d, input int n, input int nack_at,
                          input int exp_lat, input logic exp_ackerr);
      int got, s0;
      sel      = which;
      nack_idx = nack_at;
      s0       = stop_cnt;
      push_expected(which, dev, ra, d, n, nack_at);
      start_write(which, dev, ra, d, 3'(n));
      wait_done(got);
      check("done_seen", got, 32'd1);
      check("latency", cyc - t0, exp_lat);
      check("ack_error", {31'd0, o_ackerr}, {31'd0, exp_ackerr});
      check("busy_in_done", {31'd0, o_busy}, 32'd0);
      tick();
      check("done_pulse_width", {31'd0, o_done}, 32'd0);
      check("bytes_missing", exp_q.size(), 32'd0);
      check("stop_seen", stop_cnt - s0, 32'd1);
      nack_idx = -1;
   endtask

   initial begin
      int got, found, s0, d0, busy_seen;
      if0.write = 1'b0; if0.dev_addr = '0; if0.reg_addr = '0; if0.data = '0; if0.nbytes = '0; if0.sda_in = 1'b0;
      if1.write = 1'b0; if1.dev_addr = '0; if1.reg_addr = '0; if1.data = '0; if1.nbytes = '0; if1.sda_in = 1'b0;

      // Reset state
      repeat (3) tick();
      check("reset_u0_in_reset", {27'd0, if0.sda_oe, if0.scl_oe, if0.busy, if0.done, if0.ack_error}, 32'd0);
      reset = 1'b0;
      repeat (2) tick();
      check("reset_u0", {27'd0, if0.sda_oe, if0.scl_oe, if0.busy, if0.done, if0.ack_error}, 32'd0);
      check("reset_u1", {27'd0, if1.sda_oe, if1.scl_oe, if1.busy, if1.done, if1.ack_error}, 32'd0);

      // Single data byte: 0x34 0x0E 0x42
      run_txn(0, 7'h1A, 16'h000E, 32'h0000_0042, 1, -1, 465, 1'b0);
      check("start_count", start_cnt, 32'd1);

      // Three-byte burst: 0xAA 0xBB 0xCC
      run_txn(0, 7'h1A, 16'h000E, 32'h00AA_BBCC, 3, -1, 753, 1'b0);

      // NACK on the register-address byte aborts before any data
      run_txn(0, 7'h1A, 16'h000E, 32'h0000_BBCC, 2, 1, 321, 1'b1);

      // nbytes=0: address and register only (also clears ack_error on accept)
      run_txn(0, 7'h1A, 16'h000E, 32'hDEAD_BEEF, 0, -1, 321, 1'b0);

      // nbytes=7 clamps to 4
      run_txn(0, 7'h1A, 16'h000E, 32'h1122_3344, 7, -1, 897, 1'b0);

      // Reset in the middle of the register byte
      sel = 0;
      s0  = stop_cnt;
      exp_q.push_back(8'h34);
      start_write(0, 7'h1A, 16'h0000, 32'h0000_005A, 3'd1);
      found = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (mon_bytes == 1 && o_scl && o_sda) begin
            found = 1;
            break;
         end
      end
      check("reset_point_reached", found, 32'd1);
      #2 reset = 1'b1;
      #1 sample();
      check("async_reset_lines", {29'd0, o_sda, o_scl, o_busy}, 32'd0);
      tick();
      reset = 1'b0;
      check("no_stop_on_reset", stop_cnt - s0, 32'd0);
      check("reset_bytes_seen", exp_q.size(), 32'd0);
      exp_q.delete();
      run_txn(0, 7'h1A, 16'h000E, 32'h0000_0042, 1, -1, 465, 1'b0);

      // Two-byte register address, with writes pulsed while busy and in the done cycle
      sel = 1;
      s0  = stop_cnt;
      d0  = done_cnt;
      push_expected(1, 7'h1A, 16'h1234, 32'h0000_0077, 1, -1);
      start_write(1, 7'h1A, 16'h1234, 32'h0000_0077, 3'd1);
      repeat (60) tick();
      drive_req(1, 7'h55, 16'hBEEF, 32'h0000_FFFF, 3'd2);
      tick();
      if1.write = 1'b0;
      wait_done(got);
      check("u1_done_seen", got, 32'd1);
      check("u1_latency", cyc - t0, 32'd609);
      drive_req(1, 7'h55, 16'hBEEF, 32'h0000_FFFF, 3'd2);
      tick();
      if1.write = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (o_busy) busy_seen++;
      end
      check("u1_ignored_writes_busy", busy_seen, 32'd0);
      check("u1_single_done", done_cnt - d0, 32'd1);
      check("u1_bytes_missing", exp_q.size(), 32'd0);
      check("u1_stop_seen", stop_cnt - s0, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
